rms_peak_search: RTL

- Downstream consumer of the RMS core's output FIFO. Pulls RMS results over the pullout/stopout handshake in windows of cfg_len results.
- Per window it finds the peak (value and index), the minimum (value and index), and the count of results at or above a threshold.
- Presents one report per window on a push/ack handshake to the search controller.

---
 rtl/rms_peak_search.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rms_peak_search.sv
// Windowed peak/min/threshold-count search over the RMS core's result FIFO.
// One report per window is offered on a push/ack handshake.
module rms_peak_search #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [WIDTH-1:0] cfg_thresh,
    input  logic             stopin,
    input  logic [WIDTH-1:0] Xin,
    output logic             pullout,
    output logic             pushout,
    input  logic             ackin,
    output logic [WIDTH-1:0] peak_val,
    output logic [CNT_W-1:0] peak_idx,
    output logic [WIDTH-1:0] min_val,
    output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] over_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] len_reg, idx_reg, over_reg, pk_idx_reg, mn_idx_reg;
    logic [WIDTH-1:0] thresh_reg, pk_reg, mn_reg;
    logic             first_reg;

    logic [CNT_W-1:0] over_next, pk_idx_next, mn_idx_next;
    logic [WIDTH-1:0] pk_next, mn_next;
    logic             start_ok, take, last_word, restart;

    assign start_ok  = start && (cfg_len != '0);
    assign take      = (state_reg == RUN) && !stopin;
    assign last_word = (idx_reg == len_reg - CNT_W'(1));
    assign restart   = (state_reg == REPORT) && ackin && cont;

    assign pullout = take;
    assign pushout = (state_reg == REPORT);
    assign busy    = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = RUN;
            RUN:     if (take && last_word) state_next = REPORT;
            REPORT:  if (ackin) state_next = cont ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accumulator values as they would stand after absorbing the current head word.
    always_comb begin
        pk_next     = pk_reg;
        pk_idx_next = pk_idx_reg;
        mn_next     = mn_reg;
        mn_idx_next = mn_idx_reg;
        over_next   = over_reg;
        if (first_reg) begin
            pk_next     = Xin;
            pk_idx_next = '0;
            mn_next     = Xin;
            mn_idx_next = '0;
        end else begin
            if (Xin > pk_reg) begin
                pk_next     = Xin;
                pk_idx_next = idx_reg;
            end
            if (Xin < mn_reg) begin
                mn_next     = Xin;
                mn_idx_next = idx_reg;
            end
        end
        if ((Xin >= thresh_reg) && (over_reg != '1))
            over_next = over_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg    <= '0;
            thresh_reg <= '0;
            idx_reg    <= '0;
            over_reg   <= '0;
            pk_reg     <= '0;
            pk_idx_reg <= '0;
            mn_reg     <= '0;
            mn_idx_reg <= '0;
            first_reg  <= 1'b0;
            peak_val   <= '0;
            peak_idx   <= '0;
            min_val    <= '0;
            min_idx    <= '0;
            over_cnt   <= '0;
        end else begin
            if ((state_reg == IDLE && start_ok) || restart) begin
                if (state_reg == IDLE) begin
                    len_reg    <= cfg_len;
                    thresh_reg <= cfg_thresh;
                end
                idx_reg    <= '0;
                over_reg   <= '0;
                pk_reg     <= '0;
                pk_idx_reg <= '0;
                mn_reg     <= '0;
                mn_idx_reg <= '0;
                first_reg  <= 1'b1;
            end else if (take) begin
                idx_reg    <= idx_reg + CNT_W'(1);
                over_reg   <= over_next;
                pk_reg     <= pk_next;
                pk_idx_reg <= pk_idx_next;
                mn_reg     <= mn_next;
                mn_idx_reg <= mn_idx_next;
                first_reg  <= 1'b0;
                // Report includes the final word, so load from the next-values.
                if (last_word) begin
                    peak_val <= pk_next;
                    peak_idx <= pk_idx_next;
                    min_val  <= mn_next;
                    min_idx  <= mn_idx_next;
                    over_cnt <= over_next;
                end
            end
        end
    end

endmodule
